// File: rtl/ras_ctrl_pkg.sv
// Shared frontend types: the virtual-address width and the return-address-stack entry.
// Both packages sit in one file so the address width is always compiled before its users.
package riscv;
  localparam int unsigned VLEN = 39;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] ra;
  } ras_t;
endpackage

// File: rtl/ras_ctrl.sv
// Return address stack for the fetch frontend: calls push pc+2/+4, returns pop,
// and a combined call+return replaces the top entry. All outputs come straight from flops.
module ras_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  input  logic                         call_i,
  input  logic                         return_i,
  input  logic                         is_rvc_i,
  input  logic [riscv::VLEN-1:0]       pc_i,
  output logic [riscv::VLEN-1:0]       ras_o,
  output logic                         ras_valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  ras_t           stack_q [DEPTH];
  ras_t           stack_d [DEPTH];
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;

  logic                   push_ev;
  logic                   pop_ev;
  logic                   swap_ev;
  logic [riscv::VLEN-1:0] push_addr;

  assign push_ev   = valid_i & call_i & ~return_i;
  assign pop_ev    = valid_i & return_i & ~call_i;
  assign swap_ev   = valid_i & call_i & return_i;
  // Adder result is kept at VLEN bits so the top of the address space wraps to zero.
  assign push_addr = pc_i + (is_rvc_i ? riscv::VLEN'(2) : riscv::VLEN'(4));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
    end
    count_d = count_q;

    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_d[i] = '0;
      end
      count_d = '0;
    end else if (swap_ev && count_q != '0) begin
      stack_d[0].ra = push_addr;
    end else if (push_ev || swap_ev) begin
      // A swap on an empty stack has nothing to replace, so it degenerates to a push.
      stack_d[0] = '{valid: 1'b1, ra: push_addr};
      for (int i = 1; i < DEPTH; i++) begin
        stack_d[i] = stack_q[i-1];
      end
      if (count_q != CW'(DEPTH)) begin
        count_d = count_q + CW'(1);
      end
    end else if (pop_ev && count_q != '0) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        stack_d[i] = stack_q[i+1];
      end
      stack_d[DEPTH-1] = '0;
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
      count_q <= count_d;
    end
  end

  assign ras_o       = stack_q[0].ra;
  assign ras_valid_o = stack_q[0].valid;
  assign count_o     = count_q;

endmodule
